// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle MIPS control unit.
//   mc_state_t  - FSM state encoding (FETCH = 0, 4 bits)
//   OP_* / FN_* - supported opcodes and R-type funct codes
//   ALU_*       - 3-bit ALU control encodings (zero-extended at the ports)
//   aluop_t     - coarse ALU operation requested by the FSM
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } mc_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2,
        ALUOP_OR    = 2'd3
    } aluop_t;

    // ORI is the only immediate op that zero-extends and uses OR.
    function automatic aluop_t imm_aluop(input logic [5:0] op);
        return (op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
    endfunction

endpackage

// File: rtl/mc_ctrl_aludec.sv
// aludec: combinational ALU decoder.
//   aluop         - coarse operation from the control FSM
//   funct         - R-type funct field
//   aluctrl       - ALU control, zero-extended to ALUCTRL_W
//   funct_illegal - funct is not one of the supported R-type functions
//                   (depends on funct only, so the FSM can use it without
//                   creating a path back through aluop)
module aludec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  aluop_t               aluop,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] aluctrl,
    output logic                 funct_illegal
);

    logic [2:0] fn_ctrl;
    logic [2:0] ctrl;

    // Unknown funct falls back to ADD so the ALU never sees an undefined op.
    always_comb begin
        fn_ctrl       = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  fn_ctrl = ALU_ADD;
            FN_SUB:  fn_ctrl = ALU_SUB;
            FN_AND:  fn_ctrl = ALU_AND;
            FN_OR:   fn_ctrl = ALU_OR;
            FN_SLT:  fn_ctrl = ALU_SLT;
            default: funct_illegal = 1'b1;
        endcase
    end

    always_comb begin
        ctrl = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   ctrl = ALU_ADD;
            ALUOP_SUB:   ctrl = ALU_SUB;
            ALUOP_FUNCT: ctrl = fn_ctrl;
            ALUOP_OR:    ctrl = ALU_OR;
            default:     ctrl = ALU_ADD;
        endcase
    end

    assign aluctrl = ALUCTRL_W'(ctrl);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control unit (Moore FSM plus combinational decode).
//   clk, rst          - clock, synchronous active-high reset
//   op, funct         - instruction register fields
//   zero              - ALU zero flag (drives pcen in BEQ/BNE)
//   mem_rdy           - memory access complete (FETCH/MEMRD/MEMWR only)
//   pcen..pcsrc       - datapath enables and mux selects
//   aluctrl           - ALU operation, ALUCTRL_W wide
//   state_o           - current state for debug
//   illegal           - one-cycle pulse on unsupported opcode or funct
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit WAIT_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_rdy,
    output logic                 pcen,
    output logic                 iord,
    output logic                 irwrite,
    output logic                 memwrt,
    output logic                 regwrt,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic                 immzx,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] aluctrl,
    output logic [3:0]           state_o,
    output logic                 illegal
);

    mc_state_t              state_q, state_d;
    aluop_t                 aluop;
    logic                   alu_en;
    logic                   rdy;
    logic                   funct_illegal;
    logic [ALUCTRL_W-1:0]   dec_aluctrl;

    assign rdy = WAIT_EN ? mem_rdy : 1'b1;

    aludec #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_aludec (
        .aluop         (aluop),
        .funct         (funct),
        .aluctrl       (dec_aluctrl),
        .funct_illegal (funct_illegal)
    );

    // States that do not use the ALU present aluctrl = 0.
    assign aluctrl = alu_en ? dec_aluctrl : '0;
    assign state_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pcen     = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrt   = 1'b0;
        regwrt   = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        immzx    = 1'b0;
        pcsrc    = 2'b00;
        illegal  = 1'b0;
        aluop    = ALUOP_ADD;
        alu_en   = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                alu_en  = 1'b1;
                if (rdy) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alusrcb = 2'b11;
                alu_en  = 1'b1;
                case (op)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = S_RTEX;
                    OP_BEQ:           state_d = S_BEQ;
                    OP_BNE:           state_d = S_BNE;
                    OP_ADDI, OP_ORI:  state_d = S_IMMEX;
                    OP_J:             state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alu_en  = 1'b1;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                iord   = 1'b1;
                memwrt = 1'b1;
                if (rdy) state_d = S_FETCH;
            end
            S_MEMWB: begin
                regwrt   = 1'b1;
                memtoreg = 1'b1;
                state_d  = S_FETCH;
            end
            S_RTEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                alu_en  = 1'b1;
                if (funct_illegal) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                regwrt  = 1'b1;
                regdst  = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                alu_en  = 1'b1;
                pcsrc   = 2'b01;
                pcen    = (state_q == S_BEQ) ? zero : ~zero;
                state_d = S_FETCH;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = imm_aluop(op);
                alu_en  = 1'b1;
                immzx   = (op == OP_ORI);
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                // ALU op held so ALUOut sees a stable result through writeback.
                regwrt  = 1'b1;
                aluop   = imm_aluop(op);
                alu_en  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset suppresses every architectural side effect in its cycle.
        if (rst) begin
            pcen    = 1'b0;
            irwrite = 1'b0;
            memwrt  = 1'b0;
            regwrt  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, mem_rdy = 1'b0;
    logic       pcen, iord, irwrite, memwrt, regwrt, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       immzx, illegal;
    logic [2:0] aluctrl;
    logic [3:0] state_o;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
        .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrt(memwrt), .regwrt(regwrt),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .immzx(immzx), .pcsrc(pcsrc), .aluctrl(aluctrl), .state_o(state_o), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, irwrite, memwrt, regwrt, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb;
        logic       immzx;
        logic [1:0] pcsrc;
        logic [2:0] aluctrl;
        logic       illegal;
    } out_t;

    typedef struct {
        out_t  o;
        string nm;
    } exp_t;

    // Field order: st, pcen, iord, irwrite, memwrt, regwrt, regdst, memtoreg,
    //              alusrca, alusrcb, immzx, pcsrc, aluctrl, illegal
    localparam out_t F_RDY   = '{4'd0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01, 1'b0, 2'b00, 3'b010, 1'b0};
    localparam out_t F_WAIT  = '{4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01, 1'b0, 2'b00, 3'b010, 1'b0};
    localparam out_t DEC     = '{4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11, 1'b0, 2'b00, 3'b010, 1'b0};
    localparam out_t DEC_ILL = '{4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11, 1'b0, 2'b00, 3'b010, 1'b1};
    localparam out_t MADR    = '{4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 1'b0, 2'b00, 3'b010, 1'b0};
    localparam out_t MRD     = '{4'd3, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam out_t MWB     = '{4'd4, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam out_t MWB_RST = '{4'd4, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam out_t MWR     = '{4'd5, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam out_t RT_ADD  = '{4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0};
    localparam out_t RT_SLT  = '{4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0, 2'b00, 3'b111, 1'b0};
    localparam out_t RT_SUB  = '{4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0, 2'b00, 3'b110, 1'b0};
    localparam out_t RT_ILL  = '{4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0, 2'b00, 3'b010, 1'b1};
    localparam out_t AWB     = '{4'd7, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam out_t BEQ_T   = '{4'd8, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0, 2'b01, 3'b110, 1'b0};
    localparam out_t BEQ_N   = '{4'd8, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0, 2'b01, 3'b110, 1'b0};
    localparam out_t BNE_T   = '{4'd9, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0, 2'b01, 3'b110, 1'b0};
    localparam out_t BNE_N   = '{4'd9, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0, 2'b01, 3'b110, 1'b0};
    localparam out_t IEX_ORI = '{4'd10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 1'b1, 2'b00, 3'b001, 1'b0};
    localparam out_t IWB_ORI = '{4'd11,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0};
    localparam out_t IEX_ADD = '{4'd10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 1'b0, 2'b00, 3'b010, 1'b0};
    localparam out_t IWB_ADD = '{4'd11,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0};
    localparam out_t JMP     = '{4'd12,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b10, 3'b000, 1'b0};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] ORI = 6'b001101, JOP = 6'b000010, BAD = 6'b111111;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;

    // One expected entry per cycle; monitor pops at the negedge.
    task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic rdy, input out_t e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; op = o; funct = f; zero = z; mem_rdy = rdy;
        x.o = e;
        x.nm = nm;
        exp_q.push_back(x);
        mon_on = 1'b1;
    endtask

    always @(negedge clk) begin
        out_t act;
        exp_t x;
        if (mon_on) begin
            act = {state_o, pcen, iord, irwrite, memwrt, regwrt, regdst, memtoreg,
                   alusrca, alusrcb, immzx, pcsrc, aluctrl, illegal};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL no_expected_entry got=%h", act);
            end else begin
                x = exp_q.pop_front();
                if (act !== x.o) begin
                    errors++;
                    $display("FAIL %s got=%h want=%h (state got %0d want %0d)",
                             x.nm, act, x.o, act.st, x.o.st);
                end
            end
        end
    end

    initial begin
        // Reset held: FETCH loaded on the first edge, enables forced off.
        cyc(1, 0, 0, 0, 1, F_WAIT, "reset_fetch");

        // LW, mem_rdy high throughout: 5 cycles.
        cyc(0, LW, 0, 0, 1, F_RDY, "lw_fetch");
        cyc(0, LW, 0, 0, 1, DEC,   "lw_decode");
        cyc(0, LW, 0, 0, 1, MADR,  "lw_memadr");
        cyc(0, LW, 0, 0, 1, MRD,   "lw_memrd");
        cyc(0, LW, 0, 0, 1, MWB,   "lw_memwb");

        // SW: one FETCH wait, then MEMWR held 3 cycles by mem_rdy low.
        cyc(0, SW, 0, 0, 0, F_WAIT, "sw_fetch_wait");
        cyc(0, SW, 0, 0, 1, F_RDY,  "sw_fetch");
        cyc(0, SW, 0, 0, 1, DEC,    "sw_decode");
        cyc(0, SW, 0, 0, 1, MADR,   "sw_memadr");
        cyc(0, SW, 0, 0, 0, MWR,    "sw_memwr_w1");
        cyc(0, SW, 0, 0, 0, MWR,    "sw_memwr_w2");
        cyc(0, SW, 0, 0, 0, MWR,    "sw_memwr_w3");
        cyc(0, SW, 0, 0, 1, MWR,    "sw_memwr_done");

        // LW with a MEMRD wait state; mem_rdy ignored in DECODE/MEMADR.
        cyc(0, LW, 0, 0, 1, F_RDY, "lw2_fetch");
        cyc(0, LW, 0, 0, 0, DEC,   "lw2_decode_rdy_low");
        cyc(0, LW, 0, 0, 0, MADR,  "lw2_memadr_rdy_low");
        cyc(0, LW, 0, 0, 0, MRD,   "lw2_memrd_wait");
        cyc(0, LW, 0, 0, 1, MRD,   "lw2_memrd");
        cyc(0, LW, 0, 0, 1, MWB,   "lw2_memwb");

        // R-type ADD, SLT, SUB.
        cyc(0, RT, 6'b100000, 0, 1, F_RDY,  "add_fetch");
        cyc(0, RT, 6'b100000, 0, 1, DEC,    "add_decode");
        cyc(0, RT, 6'b100000, 0, 1, RT_ADD, "add_rtex");
        cyc(0, RT, 6'b100000, 0, 1, AWB,    "add_aluwb");
        cyc(0, RT, 6'b101010, 0, 1, F_RDY,  "slt_fetch");
        cyc(0, RT, 6'b101010, 0, 1, DEC,    "slt_decode");
        cyc(0, RT, 6'b101010, 0, 1, RT_SLT, "slt_rtex");
        cyc(0, RT, 6'b101010, 0, 1, AWB,    "slt_aluwb");
        cyc(0, RT, 6'b100010, 0, 1, F_RDY,  "sub_fetch");
        cyc(0, RT, 6'b100010, 0, 1, DEC,    "sub_decode");
        cyc(0, RT, 6'b100010, 0, 1, RT_SUB, "sub_rtex");
        cyc(0, RT, 6'b100010, 0, 1, AWB,    "sub_aluwb");

        // Branches, both zero values each.
        cyc(0, BEQ, 0, 0, 1, F_RDY, "beq1_fetch");
        cyc(0, BEQ, 0, 0, 1, DEC,   "beq1_decode");
        cyc(0, BEQ, 0, 1, 1, BEQ_T, "beq_taken");
        cyc(0, BEQ, 0, 0, 1, F_RDY, "beq0_fetch");
        cyc(0, BEQ, 0, 0, 1, DEC,   "beq0_decode");
        cyc(0, BEQ, 0, 0, 1, BEQ_N, "beq_not_taken");
        cyc(0, BNE, 0, 1, 1, F_RDY, "bne1_fetch");
        cyc(0, BNE, 0, 1, 1, DEC,   "bne1_decode");
        cyc(0, BNE, 0, 1, 1, BNE_N, "bne_not_taken");
        cyc(0, BNE, 0, 0, 1, F_RDY, "bne0_fetch");
        cyc(0, BNE, 0, 0, 1, DEC,   "bne0_decode");
        cyc(0, BNE, 0, 0, 1, BNE_T, "bne_taken");

        // Immediates.
        cyc(0, ORI,  0, 0, 1, F_RDY,   "ori_fetch");
        cyc(0, ORI,  0, 0, 1, DEC,     "ori_decode");
        cyc(0, ORI,  0, 0, 1, IEX_ORI, "ori_immex");
        cyc(0, ORI,  0, 0, 1, IWB_ORI, "ori_immwb");
        cyc(0, ADDI, 0, 0, 1, F_RDY,   "addi_fetch");
        cyc(0, ADDI, 0, 0, 1, DEC,     "addi_decode");
        cyc(0, ADDI, 0, 0, 1, IEX_ADD, "addi_immex");
        cyc(0, ADDI, 0, 0, 1, IWB_ADD, "addi_immwb");

        // Jump.
        cyc(0, JOP, 0, 0, 1, F_RDY, "j_fetch");
        cyc(0, JOP, 0, 0, 1, DEC,   "j_decode");
        cyc(0, JOP, 0, 0, 1, JMP,   "j_jump");

        // Illegal opcode, then illegal funct; both return to FETCH.
        cyc(0, BAD, 0, 0, 1, F_RDY,   "badop_fetch");
        cyc(0, BAD, 0, 0, 1, DEC_ILL, "badop_decode");
        cyc(0, RT, 6'b000111, 0, 1, F_RDY,  "badfn_fetch");
        cyc(0, RT, 6'b000111, 0, 1, DEC,    "badfn_decode");
        cyc(0, RT, 6'b000111, 0, 1, RT_ILL, "badfn_rtex");
        cyc(0, RT, 6'b000111, 0, 1, F_RDY,  "badfn_back_fetch");

        // Reset asserted in MEMWB suppresses the writeback.
        cyc(0, LW, 0, 0, 1, DEC,     "lw3_decode");
        cyc(0, LW, 0, 0, 1, MADR,    "lw3_memadr");
        cyc(0, LW, 0, 0, 1, MRD,     "lw3_memrd");
        cyc(1, LW, 0, 0, 1, MWB_RST, "lw3_memwb_in_reset");
        cyc(0, LW, 0, 0, 0, F_WAIT,  "after_reset_fetch");

        @(negedge clk);
        #1;
        mon_on = 1'b0;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
